trackball_decoder: RTL and testbench



---
 rtl/trackball_pkg.sv | 12 +
 rtl/trackball_axis.sv | 63 ++++++
 rtl/trackball_decoder.sv | 69 ++++++
 tb/tb_trackball_decoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/trackball_pkg.sv
// Shared types and constants for the trackball receiver.
// Position counters are CNT_W bits wide; the snapshot port packs {v, h}.
package trackball_pkg;

    localparam int SYNC_STAGES = 2;

    typedef struct packed {
        logic clk;
        logic dir;
    } axis_t;

endpackage

// File: rtl/trackball_axis.sv
// One trackball axis: input synchronizers, strobe glitch filter,
// rising-edge detect and wrapping up/down position counter.
module trackball_axis
    import trackball_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int FILTER = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             flip,
    input  axis_t            strobe,
    output logic [CNT_W-1:0] pos,
    output logic             rise
);

    localparam logic [3:0] FILT_LAST = 4'(FILTER - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dir_sync;
    logic                   clk_s;
    logic                   dir_s;
    logic                   filt;
    logic                   filt_d;
    logic [3:0]             cnt;

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dir_s = dir_sync[SYNC_STAGES-1];
    assign rise  = filt & ~filt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= '0;
            dir_sync <= '0;
            filt     <= 1'b0;
            filt_d   <= 1'b0;
            cnt      <= '0;
            pos      <= '0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], strobe.clk};
            dir_sync <= {dir_sync[SYNC_STAGES-2:0], strobe.dir};
            filt_d   <= filt;

            // A new level is accepted only after FILTER consecutive ce samples disagree.
            if (ce) begin
                if (clk_s == filt) begin
                    cnt <= '0;
                end else if (cnt == FILT_LAST) begin
                    filt <= clk_s;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end

            if (rise) begin
                pos <= (dir_s ^ flip) ? pos + CNT_W'(1) : pos - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/trackball_decoder.sv
// Trackball receiver top: two filtered axis counters plus the CPU-latched
// snapshot and the sticky step flag.
module trackball_decoder
    import trackball_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int FILTER = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic               flip,
    input  logic               h_clk,
    input  logic               h_dir,
    input  logic               v_clk,
    input  logic               v_dir,
    input  logic               latch,
    output logic [CNT_W-1:0]   h_pos,
    output logic [CNT_W-1:0]   v_pos,
    output logic [2*CNT_W-1:0] data_out,
    output logic               step_seen
);

    axis_t h_in;
    axis_t v_in;
    logic  h_rise;
    logic  v_rise;

    assign h_in = '{clk: h_clk, dir: h_dir};
    assign v_in = '{clk: v_clk, dir: v_dir};

    trackball_axis #(.CNT_W(CNT_W), .FILTER(FILTER)) u_h_axis (
        .clk    (clk),
        .reset  (reset),
        .ce     (ce),
        .flip   (flip),
        .strobe (h_in),
        .pos    (h_pos),
        .rise   (h_rise)
    );

    trackball_axis #(.CNT_W(CNT_W), .FILTER(FILTER)) u_v_axis (
        .clk    (clk),
        .reset  (reset),
        .ce     (ce),
        .flip   (flip),
        .strobe (v_in),
        .pos    (v_pos),
        .rise   (v_rise)
    );

    // Snapshot takes the pre-update counters; a step in the latch cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            step_seen <= 1'b0;
        end else begin
            if (latch) begin
                data_out <= {v_pos, h_pos};
            end
            if (h_rise || v_rise) begin
                step_seen <= 1'b1;
            end else if (latch) begin
                step_seen <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trackball_decoder.sv
// Bench for trackball_decoder: directed scenarios plus random traffic,
// every cycle compared against an event-level reference model.
module tb_trackball_decoder;

    localparam int CNT_W  = 4;
    localparam int FILTER = 2;
    localparam int MASK   = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               ce;
    logic               flip;
    logic               h_clk;
    logic               h_dir;
    logic               v_clk;
    logic               v_dir;
    logic               latch;
    logic [CNT_W-1:0]   h_pos;
    logic [CNT_W-1:0]   v_pos;
    logic [2*CNT_W-1:0] data_out;
    logic               step_seen;

    always #5 clk = ~clk;

    trackball_decoder #(.CNT_W(CNT_W), .FILTER(FILTER)) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .flip      (flip),
        .h_clk     (h_clk),
        .h_dir     (h_dir),
        .v_clk     (v_clk),
        .v_dir     (v_dir),
        .latch     (latch),
        .h_pos     (h_pos),
        .v_pos     (v_pos),
        .data_out  (data_out),
        .step_seen (step_seen)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model, index 0 = horizontal, 1 = vertical.
    // rawN_* : raw input as sampled N clock edges ago (what the synchronizer delivers).
    int raw1_c[2], raw2_c[2], raw1_d[2], raw2_d[2];
    int acc[2];     // accepted (filtered) strobe level
    int run[2];     // consecutive ce samples disagreeing with acc
    int pend[2];    // accepted 0->1 this edge; counts on the next edge
    int m_pos[2];
    int m_snap[2];
    int m_seen;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int in_c[2];
        int in_d[2];
        int stepped;
        in_c[0] = int'(h_clk); in_c[1] = int'(v_clk);
        in_d[0] = int'(h_dir); in_d[1] = int'(v_dir);
        if (reset) begin
            for (int a = 0; a < 2; a++) begin
                raw1_c[a] = 0; raw2_c[a] = 0; raw1_d[a] = 0; raw2_d[a] = 0;
                acc[a] = 0; run[a] = 0; pend[a] = 0; m_pos[a] = 0; m_snap[a] = 0;
            end
            m_seen = 0;
        end else begin
            if (latch) begin
                m_snap[0] = m_pos[0];
                m_snap[1] = m_pos[1];
            end
            stepped = 0;
            for (int a = 0; a < 2; a++) begin
                if (pend[a] != 0) begin
                    if ((raw2_d[a] ^ int'(flip)) != 0) m_pos[a] = (m_pos[a] + 1) & MASK;
                    else                               m_pos[a] = (m_pos[a] - 1) & MASK;
                    stepped = 1;
                end
            end
            if (stepped != 0)  m_seen = 1;
            else if (latch)    m_seen = 0;
            for (int a = 0; a < 2; a++) begin
                pend[a] = 0;
                if (ce) begin
                    if (raw2_c[a] == acc[a]) begin
                        run[a] = 0;
                    end else begin
                        run[a]++;
                        if (run[a] == FILTER) begin
                            acc[a]  = raw2_c[a];
                            run[a]  = 0;
                            pend[a] = acc[a];
                        end
                    end
                end
                raw2_c[a] = raw1_c[a]; raw1_c[a] = in_c[a];
                raw2_d[a] = raw1_d[a]; raw1_d[a] = in_d[a];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_val("h_pos",     32'(h_pos),     32'(m_pos[0]));
        check_val("v_pos",     32'(v_pos),     32'(m_pos[1]));
        check_val("data_out",  32'(data_out),  32'((m_snap[1] << CNT_W) | m_snap[0]));
        check_val("step_seen", 32'(step_seen), 32'(m_seen));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input int axis, input int hi, input int lo);
        if (axis == 0) h_clk = 1'b1; else v_clk = 1'b1;
        ticks(hi);
        if (axis == 0) h_clk = 1'b0; else v_clk = 1'b0;
        ticks(lo);
    endtask

    int h_left, v_left;

    initial begin
        reset = 1'b1; ce = 1'b1; flip = 1'b0; latch = 1'b0;
        h_clk = 1'b0; h_dir = 1'b0; v_clk = 1'b0; v_dir = 1'b0;
        ticks(3);
        reset = 1'b0;
        ticks(2);
        check_val("rst_h_pos", 32'(h_pos), 32'h0);
        check_val("rst_v_pos", 32'(v_pos), 32'h0);
        check_val("rst_data",  32'(data_out), 32'h00);
        check_val("rst_seen",  32'(step_seen), 32'h0);

        // Three increments, then a CPU read.
        h_dir = 1'b1;
        for (int i = 0; i < 3; i++) pulse(0, 4, 4);
        ticks(4);
        check_val("h_three", 32'(h_pos), 32'h3);
        check_val("seen_set", 32'(step_seen), 32'h1);
        latch = 1'b1; tick(); latch = 1'b0;
        check_val("latch_data", 32'(data_out), 32'h03);
        check_val("latch_clr",  32'(step_seen), 32'h0);

        // Vertical wrap down then wrap up.
        v_dir = 1'b0; ticks(3);
        pulse(1, 4, 6);
        check_val("v_wrap_dn", 32'(v_pos), 32'hF);
        v_dir = 1'b1; ticks(3);
        for (int i = 0; i < 17; i++) pulse(1, 4, 4);
        ticks(4);
        check_val("v_wrap_up", 32'(v_pos), 32'h0);

        // Reset in the middle of a strobe pulse.
        h_clk = 1'b1; ticks(3);
        reset = 1'b1; h_clk = 1'b0; tick();
        check_val("mid_rst_h", 32'(h_pos), 32'h0);
        check_val("mid_rst_d", 32'(data_out), 32'h0);
        reset = 1'b0; ticks(6);

        // Flip inverts direction; a 1-clk glitch is discarded.
        flip = 1'b1; h_dir = 1'b1; ticks(3);
        pulse(0, 4, 4); pulse(0, 4, 4);
        ticks(4);
        check_val("flip_dec", 32'(h_pos), 32'hE);
        pulse(0, 1, 10);
        check_val("glitch", 32'(h_pos), 32'hE);
        flip = 1'b0; ticks(3);

        // ce toggling every other clock stretches the filter.
        for (int i = 0; i < 20; i++) begin
            ce = (i % 2 == 0);
            h_clk = (i < 6);
            tick();
        end
        ce = 1'b1;
        check_val("ce_half", 32'(h_pos), 32'hF);

        // Latch held across a vertical step: snapshot lags the live count by one.
        for (int i = 0; i < 5; i++) pulse(1, 4, 4);
        ticks(4);
        check_val("v_five", 32'(v_pos), 32'h5);
        latch = 1'b1;
        pulse(1, 4, 6);
        latch = 1'b0;
        check_val("v_six", 32'(v_pos), 32'h6);

        // Random traffic.
        h_left = 1; v_left = 1;
        for (int i = 0; i < 4000; i++) begin
            ce    = ($urandom_range(0, 3) != 0);
            latch = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) flip  = ~flip;
            if ($urandom_range(0, 19) == 0) h_dir = ~h_dir;
            if ($urandom_range(0, 19) == 0) v_dir = ~v_dir;
            if (--h_left == 0) begin h_clk = ~h_clk; h_left = $urandom_range(1, 7); end
            if (--v_left == 0) begin v_clk = ~v_clk; v_left = $urandom_range(1, 7); end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
